// File: rtl/sfx_pkg.sv
// Shared types for the sound-effect generator: waveform selector and FSM states.
package sfx_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_RSVD   = 2'd3
  } wave_t;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/sfx_wave_shaper.sv
// Combinational phase-to-sample mapping for square, sawtooth and triangle tones.
module sfx_wave_shaper
  import sfx_pkg::*;
#(
  parameter int DAC_WIDTH = 8
) (
  input  logic [DAC_WIDTH-1:0] phase,
  input  wave_t                wave,
  output logic [DAC_WIDTH-1:0] sample
);

  logic [DAC_WIDTH-1:0] phase_x2;

  // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
  always_comb begin
    phase_x2 = {phase[DAC_WIDTH-2:0], 1'b0};
    sample   = '0;
    case (wave)
      WAVE_SAW: sample = phase;
      WAVE_TRI: sample = phase[DAC_WIDTH-1] ? ~phase_x2 : phase_x2;
      // The reserved code plays a square so a stray select still sounds sane.
      default:  sample = phase[DAC_WIDTH-1] ? '0 : '1;
    endcase
  end

endmodule

// File: rtl/sfx_generator.sv
// Prioritised multi-event tone generator: picks the highest-priority event, plays a
// shaped tone for its programmed duration and drives a registered DAC sample.
module sfx_generator
  import sfx_pkg::*;
#(
  parameter int DAC_WIDTH = 8,
  parameter int NUM_EVT   = 4,
  parameter int DIV_WIDTH = 16,
  parameter int DUR_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                rst_i,
  input  logic [NUM_EVT-1:0]                  evt_i,
  input  logic [NUM_EVT-1:0][DIV_WIDTH-1:0]   evt_period_i,
  input  logic [NUM_EVT-1:0][DUR_WIDTH-1:0]   evt_dur_i,
  input  logic [1:0]                          wave_sel_i,
  input  logic                                mute_i,
  output logic [DAC_WIDTH-1:0]                dacCount,
  output logic                                busy_o,
  output logic [$clog2(NUM_EVT)-1:0]          active_evt_o
);

  localparam int EVT_W = $clog2(NUM_EVT);

  state_t               state, state_d;
  logic [DAC_WIDTH-1:0] phase, phase_d;
  logic [DIV_WIDTH-1:0] divcnt, divcnt_d;
  logic [DUR_WIDTH-1:0] durcnt, durcnt_d;
  logic [DIV_WIDTH-1:0] period, period_d;
  wave_t                wave, wave_d;
  logic [EVT_W-1:0]     cur, cur_d;

  logic                 win_vld;
  logic [EVT_W-1:0]     win_idx;
  logic                 start;
  logic [DAC_WIDTH-1:0] shaped;
  logic [DAC_WIDTH-1:0] sample_d;

  // Ascending scan: the last qualifying channel seen is the highest-priority winner.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (evt_i[i] && (evt_dur_i[i] != '0)) begin
        win_vld = 1'b1;
        win_idx = EVT_W'(i);
      end
    end
  end

  // Equal index restarts too, so retriggering the playing event starts it afresh.
  assign start = win_vld && ((state == IDLE) || (win_idx >= cur));

  always_comb begin
    state_d  = state;
    phase_d  = phase;
    divcnt_d = divcnt;
    durcnt_d = durcnt;
    period_d = period;
    wave_d   = wave;
    cur_d    = cur;
    if (start) begin
      state_d  = PLAY;
      phase_d  = '0;
      divcnt_d = '0;
      durcnt_d = evt_dur_i[win_idx];
      period_d = (evt_period_i[win_idx] == '0) ? DIV_WIDTH'(1) : evt_period_i[win_idx];
      wave_d   = wave_t'(wave_sel_i);
      cur_d    = win_idx;
    end else begin
      case (state)
        PLAY: begin
          if (divcnt == period - DIV_WIDTH'(1)) begin
            divcnt_d = '0;
            phase_d  = phase + DAC_WIDTH'(1);
          end else begin
            divcnt_d = divcnt + DIV_WIDTH'(1);
          end
          if (durcnt == DUR_WIDTH'(1)) begin
            state_d = IDLE;
          end else begin
            durcnt_d = durcnt - DUR_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  sfx_wave_shaper #(
    .DAC_WIDTH(DAC_WIDTH)
  ) u_shaper (
    .phase (phase_d),
    .wave  (wave_d),
    .sample(shaped)
  );

  assign sample_d = ((state_d == PLAY) && !mute_i) ? shaped : '0;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      phase    <= '0;
      divcnt   <= '0;
      durcnt   <= '0;
      period   <= '0;
      wave     <= WAVE_SQUARE;
      cur      <= '0;
      dacCount <= '0;
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      divcnt   <= divcnt_d;
      durcnt   <= durcnt_d;
      period   <= period_d;
      wave     <= wave_d;
      cur      <= cur_d;
      dacCount <= sample_d;
    end
  end

  assign busy_o       = (state == PLAY);
  assign active_evt_o = (state == PLAY) ? cur : '0;

endmodule

// File: tb/tb_sfx_generator.sv
// Directed bench for sfx_generator: reset, square/saw/triangle tones, priority,
// pre-emption, zero period/duration and mute, with hand-derived expectations.
module tb_sfx_generator;

  logic               tb_clk = 1'b0;
  logic               rst_i;
  logic [3:0]         evt_i;
  logic [3:0][15:0]   evt_period_i;
  logic [3:0][15:0]   evt_dur_i;
  logic [1:0]         wave_sel_i;
  logic               mute_i;
  logic [7:0]         dacCount;
  logic               busy_o;
  logic [1:0]         active_evt_o;

  int tests_run = 0;
  int fails     = 0;

  always #5 tb_clk = ~tb_clk;

  sfx_generator #(
    .DAC_WIDTH(8),
    .NUM_EVT  (4),
    .DIV_WIDTH(16),
    .DUR_WIDTH(16)
  ) dut (
    .clk         (tb_clk),
    .rst_i       (rst_i),
    .evt_i       (evt_i),
    .evt_period_i(evt_period_i),
    .evt_dur_i   (evt_dur_i),
    .wave_sel_i  (wave_sel_i),
    .mute_i      (mute_i),
    .dacCount    (dacCount),
    .busy_o      (busy_o),
    .active_evt_o(active_evt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raise evt for exactly one rising edge; returns at the falling edge just after it.
  task automatic pulse(input logic [3:0] evt);
    evt_i = evt;
    @(negedge tb_clk);
    evt_i = '0;
  endtask

  function automatic int tri_exp(input int k);
    int p;
    p = k % 256;
    return (p < 128) ? 2 * p : 511 - 2 * p;
  endfunction

  initial begin
    rst_i        = 1'b1;
    evt_i        = '0;
    evt_period_i = '0;
    evt_dur_i    = '0;
    wave_sel_i   = 2'd0;
    mute_i       = 1'b0;
    repeat (2) @(negedge tb_clk);
    rst_i = 1'b0;
    @(negedge tb_clk);
    check("reset dac", 32'(dacCount), 0);
    check("reset busy", 32'(busy_o), 0);
    check("reset active", 32'(active_evt_o), 0);

    // Square: period 2, dur 300 -> high for 256 cycles, low for 44, then idle.
    evt_period_i[0] = 16'd2;
    evt_dur_i[0]    = 16'd300;
    wave_sel_i      = 2'd0;
    pulse(4'b0001);
    for (int k = 0; k < 300; k++) begin
      check($sformatf("sq dac k=%0d", k), 32'(dacCount), (k < 256) ? 255 : 0);
      check($sformatf("sq busy k=%0d", k), 32'(busy_o), 1);
      @(negedge tb_clk);
    end
    check("sq end busy", 32'(busy_o), 0);
    check("sq end dac", 32'(dacCount), 0);
    check("sq end active", 32'(active_evt_o), 0);

    // Sawtooth wrap: period 1, dur 260.
    evt_period_i[0] = 16'd1;
    evt_dur_i[0]    = 16'd260;
    wave_sel_i      = 2'd1;
    pulse(4'b0001);
    for (int k = 0; k < 260; k++) begin
      check($sformatf("saw dac k=%0d", k), 32'(dacCount), k % 256);
      @(negedge tb_clk);
    end
    check("saw end dac", 32'(dacCount), 0);
    check("saw end busy", 32'(busy_o), 0);

    // Priority and pre-emption, all saw at period 1.
    evt_period_i = {16'd1, 16'd1, 16'd1, 16'd1};
    evt_dur_i    = {16'd20, 16'd50, 16'd40, 16'd40};
    pulse(4'b0101);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("prio dac k=%0d", k), 32'(dacCount), k);
      check($sformatf("prio active k=%0d", k), 32'(active_evt_o), 2);
      if (k < 5) @(negedge tb_clk);
    end
    pulse(4'b0010);
    check("low prio dropped dac", 32'(dacCount), 6);
    check("low prio dropped active", 32'(active_evt_o), 2);
    pulse(4'b1000);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("preempt dac k=%0d", k), 32'(dacCount), k);
      check($sformatf("preempt active k=%0d", k), 32'(active_evt_o), 3);
      check($sformatf("preempt busy k=%0d", k), 32'(busy_o), 1);
      @(negedge tb_clk);
    end
    check("preempt end busy", 32'(busy_o), 0);
    check("preempt end active", 32'(active_evt_o), 0);

    // Zero duration: event ignored entirely.
    evt_dur_i[1] = 16'd0;
    pulse(4'b0010);
    check("dur0 busy", 32'(busy_o), 0);
    @(negedge tb_clk);
    check("dur0 busy later", 32'(busy_o), 0);
    check("dur0 dac", 32'(dacCount), 0);

    // Zero period behaves as period 1.
    evt_period_i[0] = 16'd0;
    evt_dur_i[0]    = 16'd10;
    wave_sel_i      = 2'd1;
    pulse(4'b0001);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("per0 dac k=%0d", k), 32'(dacCount), k);
      @(negedge tb_clk);
    end
    check("per0 end busy", 32'(busy_o), 0);

    // Triangle with mute window; wave_sel change mid-tone must be ignored.
    evt_period_i[0] = 16'd1;
    evt_dur_i[0]    = 16'd200;
    wave_sel_i      = 2'd2;
    pulse(4'b0001);
    for (int k = 0; k < 200; k++) begin
      check($sformatf("tri dac k=%0d", k), 32'(dacCount),
            (k >= 41 && k < 61) ? 0 : tri_exp(k));
      check($sformatf("tri busy k=%0d", k), 32'(busy_o), 1);
      mute_i = (k >= 40 && k < 60);
      if (k == 100) wave_sel_i = 2'd0;
      @(negedge tb_clk);
    end
    check("tri end busy", 32'(busy_o), 0);
    check("tri end dac", 32'(dacCount), 0);

    // Asynchronous reset mid-tone, asserted between clock edges.
    evt_period_i[3] = 16'd1;
    evt_dur_i[3]    = 16'd100;
    wave_sel_i      = 2'd0;
    pulse(4'b1000);
    repeat (3) @(negedge tb_clk);
    check("pre-reset active", 32'(active_evt_o), 3);
    check("pre-reset dac", 32'(dacCount), 255);
    #2;
    rst_i = 1'b1;
    #1;
    check("async reset dac", 32'(dacCount), 0);
    check("async reset busy", 32'(busy_o), 0);
    check("async reset active", 32'(active_evt_o), 0);
    @(negedge tb_clk);
    rst_i = 1'b0;
    repeat (5) @(negedge tb_clk);
    check("post-reset dac", 32'(dacCount), 0);
    check("post-reset busy", 32'(busy_o), 0);
    check("post-reset active", 32'(active_evt_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/sfx_generator.md
# sfx_generator

Parametrised multi-event sound-effect generator, the successor to `sound_generator`. It takes one-cycle game-event pulses (collisions, button presses, direction changes) on `NUM_EVT` prioritised channels. Each event plays a tone with a programmable pitch, duration and waveform, and the block drives a `DAC_WIDTH`-bit sample to the DAC. It sits between the game-logic FSMs and the DAC/PWM output stage.

## Interface
- `DAC_WIDTH`, 8: sample width; also the phase-counter width.
- `NUM_EVT`, 4: number of event channels; a higher index has higher priority.
- `DIV_WIDTH`, 16: width of the per-event step period.
- `DUR_WIDTH`, 16: width of the per-event duration.

- `clk`  in  1: system clock.
- `rst_i`  in  1: asynchronous, active-high reset.
- `evt_i`  in  `NUM_EVT`: one-cycle event trigger pulses.
- `evt_period_i`  in  `[NUM_EVT-1:0][DIV_WIDTH-1:0]`: clocks per phase step for each event; 0 is treated as 1.
- `evt_dur_i`  in  `[NUM_EVT-1:0][DUR_WIDTH-1:0]`: tone length in clocks; 0 means the event is ignored.
- `wave_sel_i`  in  2: waveform select: 0 square, 1 sawtooth, 2 triangle, 3 square.
- `mute_i`  in  1: forces the sample to 0; sequencing continues.
- `dacCount`  out  `DAC_WIDTH`: registered DAC sample.
- `busy_o`  out  1: high while in PLAY.
- `active_evt_o`  out  `$clog2(NUM_EVT)`: index of the event currently playing; 0 when idle.

## Operation
- **FSM states:** IDLE and PLAY.
- **Registers:** `phase` (`DAC_WIDTH` bits), `divcnt`, `durcnt`, `period`, `wave`, `cur`.
- **Winner selection:** the highest set bit of `evt_i` among channels whose `evt_dur_i` is non-zero.
- **Start, from IDLE with a winner:** go to PLAY.
  - `phase`←0, `divcnt`←0.
  - `durcnt`←`evt_dur_i[w]`; `period`←max(1, `evt_period_i[w]`).
  - `wave`←`wave_sel_i`; `cur`←w.
- **Pre-emption in PLAY:** a winner with index ≥ `cur` restarts exactly as a start, including retriggering the same event. A winner with index < `cur` is dropped; there is no queueing.
- **Phase stepping in PLAY, no pre-emption:**
  - If `divcnt`==`period`-1, then `divcnt`←0 and `phase`←`phase`+1, wrapping modulo 2^`DAC_WIDTH`.
  - Otherwise `divcnt`++.
- **Duration in PLAY, no pre-emption:**
  - If `durcnt`==1, go to IDLE.
  - Otherwise `durcnt`--.
- **Wave shaping** of the next-state phase p, with M = 2^`DAC_WIDTH`-1:
  - Square: M if the MSB of p is 0, else 0.
  - Sawtooth: p.
  - Triangle: (p<<1) if the MSB is 0, else ~(p<<1), truncated to `DAC_WIDTH` bits.
- **Sample output:** `dacCount`←shaped sample when the next state is PLAY and `mute_i`=0; otherwise 0.
- **Input sampling:** `wave_sel_i` and the period/duration inputs are sampled only at start or pre-emption. Changes mid-tone have no effect.

## Timing
- **Reset (async, immediate):** `dacCount`=0, `busy_o`=0, `active_evt_o`=0, state IDLE, all counters 0. Reset mid-tone aborts the tone; nothing resumes after release.
- **Start latency:** an `evt_i` pulse sampled at edge E gives `busy_o`=1 and the first sample on `dacCount` after E. That is 1 cycle of latency.
- **Tone length:** PLAY lasts exactly D cycles, edges E through E+D-1. At edge E+D the block returns to IDLE, with `dacCount`=0 and `busy_o`=0.
- **Phase rate:** `phase` increments once every `period` clocks. The waveform period is `period`·2^`DAC_WIDTH` clocks.
- **Pre-emption:** takes effect at the same edge the pulse is sampled, with no gap cycle.
- **`mute_i`:** combines with the next state, so the sample changes one cycle after `mute_i` changes.

## Structure
- **Package `sfx_pkg`:**
  - `wave_t` enum: WAVE_SQUARE, WAVE_SAW, WAVE_TRI, WAVE_RSVD.
  - `state_t` enum: IDLE, PLAY.
- **Sub-module `sfx_wave_shaper`:** combinational phase plus `wave_t` in, sample out, parametrised by `DAC_WIDTH`.
- **Top level:** the FSM, priority encoder, divider and duration counters.

## Test plan
- **Reset:** assert `rst_i` mid-tone between clock edges. `dacCount`, `busy_o` and `active_evt_o` go to 0 immediately and stay 0 after release.
- **Square tone:** `evt_i[0]` pulse, period 2, dur 300, square. `dacCount`=255 for cycles 0–255 after E and 0 for cycles 256–299. `busy_o` falls at E+300.
- **Sawtooth wrap:** period 1, dur 260, saw. `dacCount` runs 0,1,…,255,0,1,2,3, then 0 when idle.
- **Priority:**
  - `evt_i`=4'b0101 in one cycle: event 2 plays and `active_evt_o`=2.
  - A later `evt_i[1]` pulse is ignored.
  - A later `evt_i[3]` pulse pre-empts: phase restarts and the `dacCount` sequence restarts on the next cycle.
- **Zero cases:**
  - Dur 0 on event 1: no `busy_o`.
  - Period 0 with saw: phase increments every clock, the same as period 1.
- **Mute:** toggle `mute_i` during a triangle tone. `dacCount` is 0 while muted; on unmute it resumes at the un-muted phase value, with timing unchanged.
